seg7_scan_decoder: RTL

Inverse of the team's BCD-to-7-segment path. Monitors a multiplexed, active-low 7-segment scan bus (digit enables plus segment lines) and recovers the displayed BCD digits. Each digit is sampled only after it has been stable for a programmable number of cycles. When every digit position has been captured, a complete frame is published. Used for display self-check and loopback verification of the display driver.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_pattern_to_bcd.sv | 36 +++
 rtl/seg7_scan_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | seg7_pkg : active-low 7-segment patterns and scan-decoder FSM states     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package seg7_pkg;

  // Segment order {A,B,C,D,E,F,G}, active-low
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_to_bcd.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | seg7_pattern_to_bcd : active-low segment pattern -> BCD code/blank/err   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module seg7_pattern_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    code_o  = BCD_INVALID;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (seg_i)
      SEG_0:     code_o = 4'd0;
      SEG_1:     code_o = 4'd1;
      SEG_2:     code_o = 4'd2;
      SEG_3:     code_o = 4'd3;
      SEG_4:     code_o = 4'd4;
      SEG_5:     code_o = 4'd5;
      SEG_6:     code_o = 4'd6;
      SEG_7:     code_o = 4'd7;
      SEG_8:     code_o = 4'd8;
      SEG_9:     code_o = 4'd9;
      SEG_BLANK: blank_o = 1'b1;
      default:   err_o   = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | seg7_scan_decoder : recovers BCD digits from a multiplexed 7-seg bus     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   an,
  input  logic [6:0]            seg,
  output logic [4*N_DIGITS-1:0] bcd_frame,
  output logic [N_DIGITS-1:0]   blank_mask,
  output logic [N_DIGITS-1:0]   err_mask,
  output logic                  frame_valid
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_DIGITS-1:0]     prev_an_q;
  logic [6:0]              prev_seg_q;

  logic [4*N_DIGITS-1:0]   slot_code_q, slot_code_d;
  logic [N_DIGITS-1:0]     slot_blank_q, slot_blank_d;
  logic [N_DIGITS-1:0]     slot_err_q, slot_err_d;
  logic [N_DIGITS-1:0]     cap_mask_q, cap_mask_d;

  logic [4*N_DIGITS-1:0]   frame_q, frame_d;
  logic [N_DIGITS-1:0]     blank_q, blank_d;
  logic [N_DIGITS-1:0]     err_q, err_d;
  logic                    fv_q, fv_d;

  logic                    w_same, w_valid_sel, w_capture;
  logic [N_DIGITS-1:0]     w_sel;
  logic [3:0]              w_code;
  logic                    w_blank, w_err;

  assign w_sel       = ~an;
  assign w_valid_sel = $onehot(w_sel);
  assign w_same      = ({an, seg} == {prev_an_q, prev_seg_q});

  seg7_pattern_to_bcd u_dec (
    .seg_i   (seg),
    .code_o  (w_code),
    .blank_o (w_blank),
    .err_o   (w_err)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_capture = 1'b0;
    case (state_q)
      WAIT: begin
        if (w_valid_sel) begin
          state_d = SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      SETTLE: begin
        if (!w_same || !w_valid_sel) begin
          state_d = w_valid_sel ? SETTLE : WAIT;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          w_capture = 1'b1;
          state_d   = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        // A captured digit is not re-sampled until the bus changes
        if (!w_same) begin
          state_d = w_valid_sel ? SETTLE : WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    slot_code_d  = slot_code_q;
    slot_blank_d = slot_blank_q;
    slot_err_d   = slot_err_q;
    cap_mask_d   = cap_mask_q;
    frame_d      = frame_q;
    blank_d      = blank_q;
    err_d        = err_q;
    fv_d         = 1'b0;
    if (w_capture) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (w_sel[i]) begin
          slot_code_d[4*i +: 4] = w_code;
          slot_blank_d[i]       = w_blank;
          slot_err_d[i]         = w_err;
        end
      end
      cap_mask_d = cap_mask_q | w_sel;
      // Publish includes the capture taking place on this same edge
      if (&cap_mask_d) begin
        frame_d    = slot_code_d;
        blank_d    = slot_blank_d;
        err_d      = slot_err_d;
        fv_d       = 1'b1;
        cap_mask_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT;
      cnt_q        <= '0;
      prev_an_q    <= '1;
      prev_seg_q   <= SEG_BLANK;
      slot_code_q  <= '0;
      slot_blank_q <= '0;
      slot_err_q   <= '0;
      cap_mask_q   <= '0;
      frame_q      <= '0;
      blank_q      <= '0;
      err_q        <= '0;
      fv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_an_q    <= an;
      prev_seg_q   <= seg;
      slot_code_q  <= slot_code_d;
      slot_blank_q <= slot_blank_d;
      slot_err_q   <= slot_err_d;
      cap_mask_q   <= cap_mask_d;
      frame_q      <= frame_d;
      blank_q      <= blank_d;
      err_q        <= err_d;
      fv_q         <= fv_d;
    end
  end

  assign bcd_frame   = frame_q;
  assign blank_mask  = blank_q;
  assign err_mask    = err_q;
  assign frame_valid = fv_q;

endmodule
`default_nettype wire
